// File: rtl/transpose_buffer.sv
// transpose_buffer
//   Ping-pong transpose memory between the row-DCT and column-DCT stages.
//   An N x N block of W-bit coefficients arrives row-major on the input
//   stream and leaves column-major on the output stream. Two banks let one
//   block fill while the previous block drains.
//
// Parameters
//   W            coefficient width (>= 2)
//   N            block dimension, power of two (>= 2)
//
// Ports
//   clk          clock, rising edge
//   clr_n        asynchronous active-low reset
//   in_valid     producer has a word on in_data
//   in_ready     buffer accepts a word this cycle
//   in_data      row-major input word
//   out_valid    out_data holds a valid word
//   out_ready    consumer accepts out_data this cycle
//   out_data     column-major output word, 0 when out_valid=0
//   out_last     high with the final word of a block
//   row_mode     (TPB_ROWMODE_EN only) 1 = drain this block row-major
//
// Build option
//   TPB_ROWMODE_EN  adds row_mode and a per-bank mode bit; a bank whose
//                   mode bit is set drains in arrival order.
//
// Bank life cycle (implicit, derived from full/wp/rp/ri)
//   state    | meaning
//   EMPTY    | full=0, not the write bank
//   FILLING  | wp points at the bank
//   FULL     | full=1, waiting for the read side
//   DRAINING | rp points at the bank and ri > 0
module transpose_buffer #(
    parameter int W = 16,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last
`ifdef TPB_ROWMODE_EN
    ,
    input  logic         row_mode
`endif
);

    localparam int LOGN  = $clog2(N);
    localparam int DEPTH = N * N;
    localparam int AW    = 2 * LOGN;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [W-1:0]  mem_q [2][DEPTH];
    logic [W-1:0]  mem_d [2][DEPTH];
    logic [1:0]    full_q, full_d;
    logic          wp_q, wp_d;
    logic          rp_q, rp_d;
    logic [AW-1:0] wi_q, wi_d;
    logic [AW-1:0] ri_q, ri_d;
`ifdef TPB_ROWMODE_EN
    logic [1:0]    mode_q, mode_d;
`endif

    logic          in_fire;
    logic          out_fire;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rd_addr_tr;

    // Index k = {k/N, k%N}; the transposed address puts k%N in the row
    // field and k/N in the column field.
    assign rd_addr_tr = {ri_q[LOGN-1:0], ri_q[AW-1:LOGN]};

`ifdef TPB_ROWMODE_EN
    assign rd_addr = mode_q[rp_q] ? ri_q : rd_addr_tr;
`else
    assign rd_addr = rd_addr_tr;
`endif

    // Handshake qualifiers come straight from registered flags, so a bank
    // freed by its final read only reopens for writing on the next cycle.
    assign in_ready  = !full_q[wp_q];
    assign out_valid = full_q[rp_q];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign out_data  = out_valid ? mem_q[rp_q][rd_addr] : '0;
    assign out_last  = out_valid && (ri_q == LAST_IDX);

    always_comb begin
        mem_d  = mem_q;
        full_d = full_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        wi_d   = wi_q;
        ri_d   = ri_q;
`ifdef TPB_ROWMODE_EN
        mode_d = mode_q;
`endif

        if (in_fire) begin
            mem_d[wp_q][wi_q] = in_data;
`ifdef TPB_ROWMODE_EN
            if (wi_q == '0) begin
                mode_d[wp_q] = row_mode;
            end
`endif
            if (wi_q == LAST_IDX) begin
                full_d[wp_q] = 1'b1;
                wp_d         = !wp_q;
                wi_d         = '0;
            end else begin
                wi_d = wi_q + 1'b1;
            end
        end

        // A write can never target the bank being released here: that bank
        // is full, so in_ready is low whenever wp == rp.
        if (out_fire) begin
            if (ri_q == LAST_IDX) begin
                full_d[rp_q] = 1'b0;
                rp_d         = !rp_q;
                ri_d         = '0;
            end else begin
                ri_d = ri_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    mem_q[b][a] <= '0;
                end
            end
            full_q <= '0;
            wp_q   <= 1'b0;
            rp_q   <= 1'b0;
            wi_q   <= '0;
            ri_q   <= '0;
`ifdef TPB_ROWMODE_EN
            mode_q <= '0;
`endif
        end else begin
            mem_q  <= mem_d;
            full_q <= full_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            wi_q   <= wi_d;
            ri_q   <= ri_d;
`ifdef TPB_ROWMODE_EN
            mode_q <= mode_d;
`endif
        end
    end

endmodule

// File: tb/tb_transpose_buffer.sv
// tb_transpose_buffer
//   Directed bench for transpose_buffer with N=8, W=16.
//   Inputs are driven 1 time unit after each rising edge and outputs are
//   observed at that same point, well away from the next edge.
module tb_transpose_buffer;

    localparam int W = 16;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         clr_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
`ifdef TPB_ROWMODE_EN
    logic         row_mode;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    transpose_buffer #(.W(W), .N(N)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef TPB_ROWMODE_EN
        ,
        .row_mode  (row_mode)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Position in block-major transpose order -> index of the source word.
    function automatic int tr_src(input int j);
        int b, k;
        b = j / 64;
        k = j % 64;
        return b * 64 + (k % 8) * 8 + k / 8;
    endfunction

    function automatic logic [W-1:0] rnd_val(input int i);
        return W'((i * 37 + 11) % 65536);
    endfunction

    initial begin
        int acc, sent, recv, cyc;
        logic prev_stall, prev_last;
        logic [W-1:0] prev_data;

        clr_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef TPB_ROWMODE_EN
        row_mode  = 1'b0;
`endif
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        clr_n = 1'b1;
        tick();

        // Fill one block with the consumer stalled, then drain it.
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            chk("a_in_ready", in_ready, 1);
            if (i == 0) chk("a_no_early_valid", out_valid, 0);
            tick();
        end
        in_valid = 1'b0;
        chk("a_latency_valid", out_valid, 1);
        chk("a_first_word", out_data, 0);
        tick();
        chk("a_stall_hold", out_data, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            chk("a_out_valid", out_valid, 1);
            chk("a_out_data", out_data, (k % 8) * 8 + k / 8);
            chk("a_out_last", out_last, (k == 63) ? 1 : 0);
            tick();
        end
        chk("a_valid_drop", out_valid, 0);
        chk("a_data_zero", out_data, 0);
        chk("a_last_zero", out_last, 0);
        out_ready = 1'b0;

        // Consumer stalled, producer always valid: exactly two banks fill.
        acc = 0;
        for (int c = 0; c < 200; c++) begin
            in_valid = 1'b1;
            in_data  = W'(acc);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("b_accepted", acc, 128);
        chk("b_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        for (int j = 0; j < 128; j++) begin
            chk("b_out_data", out_data, tr_src(j));
            chk("b_out_last", out_last, (j % 64 == 63) ? 1 : 0);
            tick();
        end
        chk("b_empty", out_valid, 0);
        chk("b_in_ready_back", in_ready, 1);

        // Continuous streaming over three blocks.
        sent = 0;
        recv = 0;
        cyc  = 0;
        out_ready = 1'b1;
        while (recv < 192 && cyc < 600) begin
            in_valid = (sent < 192);
            in_data  = W'(sent);
            if (sent < 192) chk("c_in_ready", in_ready, 1);
            if (out_valid) begin
                chk("c_out_data", out_data, tr_src(recv));
                chk("c_out_last", out_last, (recv % 64 == 63) ? 1 : 0);
                recv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("c_recv_count", recv, 192);
        chk("c_drained", out_valid, 0);

        // Random flow control over four blocks.
        sent = 0;
        recv = 0;
        cyc  = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        while (recv < 256 && cyc < 4000) begin
            if (prev_stall) begin
                chk("d_stall_data", out_data, prev_data);
                chk("d_stall_last", out_last, prev_last);
            end
            in_valid  = (sent < 256) && ($urandom_range(0, 1) == 1);
            in_data   = rnd_val(sent);
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                chk("d_out_data", out_data, rnd_val(tr_src(recv)));
                chk("d_out_last", out_last, (recv % 64 == 63) ? 1 : 0);
                recv++;
            end
            if (in_valid && in_ready) sent++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("d_recv_count", recv, 256);
        chk("d_drained", out_valid, 0);

        // Reset in the middle of filling.
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            in_data  = W'(900 + i);
            tick();
        end
        in_valid = 1'b0;
        clr_n = 1'b0;
        #1;
        chk("e1_in_ready", in_ready, 1);
        chk("e1_out_valid", out_valid, 0);
        tick();
        clr_n = 1'b1;
        tick();

        // Reset while a full bank is draining.
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = W'(300 + i);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("e2_draining", out_data, 300 + 5 * 8);
        out_ready = 1'b0;
        clr_n = 1'b0;
        #1;
        chk("e2_out_valid", out_valid, 0);
        chk("e2_out_data", out_data, 0);
        chk("e2_out_last", out_last, 0);
        chk("e2_in_ready", in_ready, 1);
        tick();
        clr_n = 1'b1;
        tick();

        // Fresh block after reset begins at element 0.
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = W'(500 + i);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            chk("e3_out_data", out_data, 500 + (k % 8) * 8 + k / 8);
            chk("e3_out_last", out_last, (k == 63) ? 1 : 0);
            tick();
        end
        chk("e3_drained", out_valid, 0);
        out_ready = 1'b0;

`ifdef TPB_ROWMODE_EN
        // Block A pass-through, block B transposed.
        for (int i = 0; i < 128; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            row_mode = (i == 0) ? 1'b1 : ((i == 64) ? 1'b0 : (i < 64));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 128; j++) begin
            chk("f_out_data", out_data, (j < 64) ? j : tr_src(j));
            tick();
        end
        out_ready = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
